// File: rtl/pattern_mealy_pkg.sv
// Shared types and elaboration-time helpers for pattern_mealy: state width and
// the KMP transition/border functions that build the next-state table.
package pattern_mealy_pkg;

  localparam int PAT_MAX     = 16;
  localparam int STATE_W_MAX = 4;

  typedef logic [PAT_MAX-1:0]     pat_t;
  typedef logic [STATE_W_MAX-1:0] state_t;

  // Register width needed to count 0..len-1 matched bits, never below 1.
  function automatic int state_w(input int len);
    int w;
    w = (len > 1) ? $clog2(len) : 1;
    return w;
  endfunction

  // Longest proper border of the pattern: the overlap kept after a full match.
  // Received-order bit p of the pattern is pattern[len-1-p].
  function automatic int border(input pat_t pattern, input int len);
    int  best;
    bit  ok;
    best = 0;
    for (int k = 1; k < len; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++)
        if (pattern[len-1-i] != pattern[k-1-i]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  // Matched-prefix length after seeing bit b with st bits already matched.
  function automatic state_t next_state(input pat_t pattern, input int len,
                                        input int st, input logic b);
    logic [PAT_MAX:0] s;
    int               n;
    int               best;
    bit               ok;
    s    = '0;
    best = 0;
    if (b == pattern[len-1-st] && st == len-1) begin
      best = border(pattern, len);
    end else begin
      // Candidate string: the st matched prefix bits followed by b.
      for (int j = 0; j < st; j++) s[j] = pattern[len-1-j];
      s[st] = b;
      n = st + 1;
      for (int k = 1; k <= n && k < len; k++) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (pattern[len-1-i] != s[n-k+i]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return state_t'(best);
  endfunction

endpackage

// File: rtl/pattern_mealy_ctr.sv
// Saturating match counter for pattern_mealy; exists only when
// PATTERN_MEALY_COUNT_EN is defined.
`ifdef PATTERN_MEALY_COUNT_EN
module pattern_mealy_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    count <= '0;
    else if (inc && count != '1)   count <= count + CNT_W'(1);
  end

endmodule
`endif

// File: rtl/pattern_mealy.sv
// pattern_mealy: Mealy serial pattern detector with overlapping (KMP) matching.
// Define PATTERN_MEALY_COUNT_EN to add the saturating match counter port `count`.
module pattern_mealy
  import pattern_mealy_pkg::*;
#(
  parameter int                 PAT_LEN = 2,
  parameter logic [PAT_LEN-1:0] PATTERN = 2'b01
`ifdef PATTERN_MEALY_COUNT_EN
  , parameter int               CNT_W   = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  output logic             y
`ifdef PATTERN_MEALY_COUNT_EN
  , output logic [CNT_W-1:0] count
`endif
);

  localparam int            SW    = state_w(PAT_LEN);
  localparam int            NS    = 1 << SW;
  localparam pat_t          PAT16 = pat_t'(PATTERN);
  localparam logic [SW-1:0] LAST  = SW'(PAT_LEN - 1);

  logic [SW-1:0] state;
  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  // Transition table folded to constants; unreachable encodings park at 0.
  for (genvar g = 0; g < NS; g++) begin : g_tbl
    if (g < PAT_LEN) begin : g_live
      localparam state_t N0 = next_state(PAT16, PAT_LEN, g, 1'b0);
      localparam state_t N1 = next_state(PAT16, PAT_LEN, g, 1'b1);
      assign nxt0[g] = N0[SW-1:0];
      assign nxt1[g] = N1[SW-1:0];
    end else begin : g_dead
      assign nxt0[g] = '0;
      assign nxt1[g] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= '0;
    else        state <= a ? nxt1[state] : nxt0[state];
  end

  // Same-cycle response: y follows a combinationally and is masked by reset.
  assign y = reset & (state == LAST) & (a == PATTERN[0]);

`ifdef PATTERN_MEALY_COUNT_EN
  pattern_mealy_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (y),
    .count (count)
  );
`endif

endmodule

// File: tb/tb_pattern_mealy.sv
// Bench for pattern_mealy: two instances ("01" and "101") on one shared stream,
// checked against a history-based reference model of pattern matching.
module tb_pattern_mealy;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a = 1'b0;
  logic y, y3;
`ifdef PATTERN_MEALY_COUNT_EN
  logic [1:0] count, count3;
`endif

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [15:0] P2 = 16'b01;
  localparam logic [15:0] P3 = 16'b101;

  bit hist[$];
  int cnt = 0, cnt3 = 0;
  int ypulses = 0;
  logic last_y3;

  always #5 clk = ~clk;

  pattern_mealy dut (
    .clk(clk), .reset(reset), .a(a), .y(y)
`ifdef PATTERN_MEALY_COUNT_EN
    , .count(count)
`endif
  );

  pattern_mealy #(.PAT_LEN(3), .PATTERN(3'b101)
`ifdef PATTERN_MEALY_COUNT_EN
    , .CNT_W(2)
`endif
  ) dut3 (
    .clk(clk), .reset(reset), .a(a), .y(y3)
`ifdef PATTERN_MEALY_COUNT_EN
    , .count(count3)
`endif
  );

`ifdef PATTERN_MEALY_COUNT_EN
  defparam dut.CNT_W = 2;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // True when the last k received bits equal the first k pattern bits.
  function automatic bit tail_is_prefix(input bit h[$], input int k,
                                        input logic [15:0] p, input int len);
    if (k > h.size()) return 1'b0;
    for (int i = 0; i < k; i++)
      if (h[h.size()-k+i] != p[len-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_state(input bit h[$], input logic [15:0] p, input int len);
    int best = 0;
    for (int k = 1; k < len; k++)
      if (tail_is_prefix(h, k, p, len)) best = k;
    return best;
  endfunction

  function automatic bit exp_y(input bit h[$], input bit av, input logic [15:0] p, input int len);
    bit h2[$];
    h2 = h;
    h2.push_back(av);
    return tail_is_prefix(h2, len, p, len);
  endfunction

  task automatic model_edge(input bit av);
    if (exp_y(hist, av, P2, 2) && cnt < 3)  cnt++;
    if (exp_y(hist, av, P3, 3) && cnt3 < 3) cnt3++;
    hist.push_back(av);
    if (hist.size() > 32) void'(hist.pop_front());
  endtask

  // Called just after a rising edge; drives a, checks at the falling edge.
  task automatic cyc(input bit av);
    a = av;
    @(negedge clk);
    chk("y",      y,          exp_y(hist, av, P2, 2));
    chk("state",  dut.state,  exp_state(hist, P2, 2));
    chk("y3",     y3,         exp_y(hist, av, P3, 3));
    chk("state3", dut3.state, exp_state(hist, P3, 3));
`ifdef PATTERN_MEALY_COUNT_EN
    chk("count",  count,  cnt);
    chk("count3", count3, cnt3);
`endif
    ypulses += int'(y);
    last_y3 = y3;
    @(posedge clk);
    model_edge(av);
    #1;
  endtask

  // Pulls reset low partway through a cycle, releases it a cycle later.
  task automatic do_reset();
    reset = 1'b0;
    #3;
    chk("rst_y",      y,          0);
    chk("rst_y3",     y3,         0);
    chk("rst_state",  dut.state,  0);
    chk("rst_state3", dut3.state, 0);
`ifdef PATTERN_MEALY_COUNT_EN
    chk("rst_count", count, 0);
`endif
    hist.delete();
    cnt = 0; cnt3 = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seq2[12];
    logic [4:0] y3bits;
    bit s5[5];
    seq2 = '{0,0,1,1,0,0,1,1,0,0,1,1};
    s5   = '{1,0,1,0,1};

    // 1: reset low 12ns, then first edge with a=0 reaches state 1
    #8;
    chk("t1_rst_state", dut.state, 0);
    chk("t1_rst_y",     y,         0);
    #4;
    reset = 1'b1;
    @(posedge clk);
    model_edge(1'b0);
    #1;
    chk("t1_state", dut.state, 1);

    // 2: 0,0,1,1 x3, each held two cycles -> three pulses
    do_reset();
    ypulses = 0;
    foreach (seq2[i]) begin
      cyc(seq2[i]);
      cyc(seq2[i]);
    end
    chk("t2_pulses", ypulses, 3);

    // 3: a held 1 -> never matches "01"
    do_reset();
    ypulses = 0;
    for (int i = 0; i < 10; i++) cyc(1'b1);
    chk("t3_pulses", ypulses, 0);
    chk("t3_state",  dut.state, 0);

    // 4: "101" overlap on 1,0,1,0,1 -> pulses on bits 3 and 5
    do_reset();
    y3bits = '0;
    foreach (s5[i]) begin
      cyc(s5[i]);
      y3bits[i] = last_y3;
    end
    chk("t4_y3bits", y3bits, 5'b10100);

    // 5: async reset mid-cycle while state=1 and a=1
    do_reset();
    cyc(1'b0);
    a = 1'b1;
    #2;
    chk("t5_y_before", y, 1);
    reset = 1'b0;
    #1;
    chk("t5_y_drop",  y,         0);
    chk("t5_state0",  dut.state, 0);
    hist.delete();
    cnt = 0; cnt3 = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef PATTERN_MEALY_COUNT_EN
    // 6: CNT_W=2 saturates at 3 after five matches
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0);
      cyc(1'b1);
      chk("t6_count", count, (i < 3) ? i + 1 : 3);
    end
`endif

    // randomized stream with occasional mid-cycle resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      else cyc(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
